// File: rtl/delay_prog_edge.sv
// Counter-based programmable edge delay and glitch filter for the stepdown control loop.
// Delayed edges must persist for dly_q+1 cycles to reach o; shorter pulses are swallowed with a flt pulse.
module delay_prog_edge #(
  parameter int unsigned DLY_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0,
  parameter int unsigned DLY_RST     = 10,
  parameter logic [1:0]  MODE_RST    = 2'd0
) (
  input  logic             CELCLK,
  input  logic             CELRSTN,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             CELSUB,
  input  logic             i,
  input  logic             cfg_ld,
  input  logic [DLY_W-1:0] dly_cfg,
  input  logic [1:0]       mode_cfg,
  output logic             o,
  output logic             busy,
  output logic             evt,
  output logic             flt
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [1:0]       MODE_RISE   = 2'd0;
  localparam logic [1:0]       MODE_FALL   = 2'd1;
  localparam logic [1:0]       MODE_BOTH   = 2'd2;
  localparam logic [1:0]       MODE_BYPASS = 2'd3;
  localparam logic [DLY_W-1:0] CNT_ZERO    = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] CNT_ONE     = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_RST_V   = DLY_W'(DLY_RST);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [1:0]             mode_q, mode_d;
  logic [DLY_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   o_q, o_d;
  logic                   busy_q, busy_d;
  logic                   evt_q, evt_d;
  logic                   flt_q, flt_d;
  logic                   si_s;
  logic                   delayed_s;
  logic                   unused_pins_s;

  // Supply pins exist only for schematic compatibility.
  assign unused_pins_s = ^{CELV, CELG, CELSUB};
  assign si_s          = sync_q[SYNC_STAGES-1];

  // State, config and output registers.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      dly_q   <= DLY_RST_V;
      mode_q  <= MODE_RST;
      cnt_q   <= CNT_ZERO;
      state_q <= IDLE;
      o_q     <= RST_VAL;
      busy_q  <= 1'b0;
      evt_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
      flt_q   <= flt_d;
    end
  end

  // Edge classification, config capture and the IDLE/COUNT filter FSM.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i};
    dly_d   = dly_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    o_d     = o_q;
    flt_d   = 1'b0;

    if (cfg_ld) begin
      dly_d  = dly_cfg;
      mode_d = mode_cfg;
    end else begin
      dly_d  = dly_q;
      mode_d = mode_q;
    end

    case (mode_q)
      MODE_RISE: delayed_s = si_s & ~o_q;
      MODE_FALL: delayed_s = ~si_s & o_q;
      MODE_BOTH: delayed_s = 1'b1;
      default:   delayed_s = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (si_s == o_q) begin
          state_d = IDLE;
        end else if (!delayed_s || (dly_q == CNT_ZERO)) begin
          o_d = si_s;
        end else begin
          // Loaded with dly_q-1 so expiry lands dly_q edges after the direct path.
          state_d = COUNT;
          cnt_d   = dly_q - CNT_ONE;
        end
      end
      COUNT: begin
        if (mode_q == MODE_BYPASS) begin
          o_d     = si_s;
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else if (si_s == o_q) begin
          flt_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          o_d     = si_s;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase

    evt_d  = o_d ^ o_q;
    busy_d = (state_d == COUNT);
  end

  assign o    = o_q;
  assign busy = busy_q;
  assign evt  = evt_q;
  assign flt  = flt_q;

endmodule

// File: tb/tb_delay_prog_edge.sv
// Directed testbench for delay_prog_edge: latencies, glitch filtering, mid-count config and reset.
module tb_delay_prog_edge;

  logic       CELCLK = 1'b0;
  logic       CELRSTN;
  logic       CELV = 1'b1;
  logic       CELG = 1'b0;
  logic       CELSUB = 1'b0;
  logic       i;
  logic       cfg_ld;
  logic [7:0] dly_cfg;
  logic [1:0] mode_cfg;
  logic       o, busy, evt, flt;

  int checks = 0;
  int errors = 0;

  delay_prog_edge dut (
    .CELCLK  (CELCLK),
    .CELRSTN (CELRSTN),
    .CELV    (CELV),
    .CELG    (CELG),
    .CELSUB  (CELSUB),
    .i       (i),
    .cfg_ld  (cfg_ld),
    .dly_cfg (dly_cfg),
    .mode_cfg(mode_cfg),
    .o       (o),
    .busy    (busy),
    .evt     (evt),
    .flt     (flt)
  );

  always #5 CELCLK = ~CELCLK;

  task automatic step();
    @(posedge CELCLK);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int n, input logic eo, input logic eb,
                      input logic ee, input logic ef);
    chk({tag, ".o"}, n, {31'd0, o}, {31'd0, eo});
    chk({tag, ".busy"}, n, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".evt"}, n, {31'd0, evt}, {31'd0, ee});
    chk({tag, ".flt"}, n, {31'd0, flt}, {31'd0, ef});
  endtask

  task automatic load_cfg(input logic [7:0] d, input logic [1:0] m);
    cfg_ld   = 1'b1;
    dly_cfg  = d;
    mode_cfg = m;
    step();
    cfg_ld = 1'b0;
  endtask

  initial begin
    CELRSTN  = 1'b0;
    i        = 1'b0;
    cfg_ld   = 1'b0;
    dly_cfg  = 8'd0;
    mode_cfg = 2'd0;

    // Reset state
    step();
    step();
    chk4("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    CELRSTN = 1'b1;
    step();

    // Default dly 10, mode 0: rise delayed by 2+10
    for (int n = 0; n <= 13; n++) begin
      i = 1'b1;
      step();
      chk4("dflt_rise", n, n >= 12, (n >= 2) && (n <= 11), n == 12, 1'b0);
    end

    // Mode 0 fall is direct
    for (int n = 0; n <= 3; n++) begin
      i = 1'b0;
      step();
      chk4("m0_fall", n, n < 2, 1'b0, n == 2, 1'b0);
    end

    // Mode 2, 8-cycle pulse is filtered
    load_cfg(8'd10, 2'd2);
    for (int n = 0; n <= 20; n++) begin
      i = (n < 8);
      step();
      chk4("m2_glitch", n, 1'b0, (n >= 2) && (n <= 9), 1'b0, n == 10);
    end

    // Mode 2, 11-cycle pulse passes, delayed by 12
    for (int n = 0; n <= 30; n++) begin
      i = (n < 11);
      step();
      chk4("m2_pass", n, (n >= 12) && (n <= 22),
           ((n >= 2) && (n <= 11)) || ((n >= 13) && (n <= 22)),
           (n == 12) || (n == 23), 1'b0);
    end

    // Zero delay: both edges at 2-cycle latency
    load_cfg(8'd0, 2'd2);
    for (int n = 0; n <= 8; n++) begin
      i = (n < 5);
      step();
      chk4("dly0", n, (n >= 2) && (n <= 6), 1'b0, (n == 2) || (n == 7), 1'b0);
    end

    // Maximum delay 255
    load_cfg(8'd255, 2'd2);
    for (int n = 0; n <= 258; n++) begin
      i = 1'b1;
      step();
      chk4("dly255", n, n >= 257, (n >= 2) && (n <= 256), n == 257, 1'b0);
    end

    // cfg_ld mid-count: pending fall keeps 10, next rise uses 3
    load_cfg(8'd10, 2'd2);
    for (int n = 0; n <= 14; n++) begin
      i        = 1'b0;
      cfg_ld   = (n == 4);
      dly_cfg  = 8'd3;
      mode_cfg = 2'd2;
      step();
      chk4("mid_dly_old", n, n < 12, (n >= 2) && (n <= 11), n == 12, 1'b0);
    end
    cfg_ld = 1'b0;
    for (int n = 0; n <= 7; n++) begin
      i = 1'b1;
      step();
      chk4("mid_dly_new", n, n >= 5, (n >= 2) && (n <= 4), n == 5, 1'b0);
    end

    // Mode 3 loaded mid-count aborts the count without flt
    for (int n = 0; n <= 6; n++) begin
      i        = 1'b0;
      cfg_ld   = (n == 3);
      dly_cfg  = 8'd3;
      mode_cfg = 2'd3;
      step();
      chk4("mid_bypass", n, n < 4, (n >= 2) && (n <= 3), n == 4, 1'b0);
    end
    cfg_ld = 1'b0;

    // Async reset mid-count
    load_cfg(8'd10, 2'd0);
    for (int n = 0; n <= 4; n++) begin
      i = 1'b1;
      step();
      chk4("pre_rst", n, 1'b0, n >= 2, 1'b0, 1'b0);
    end
    #2;
    CELRSTN = 1'b0;
    i       = 1'b0;
    #1;
    chk4("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    CELRSTN = 1'b1;
    for (int n = 0; n <= 14; n++) begin
      step();
      chk4("post_rst", n, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_prog_edge.md
# delay_prog_edge

Programmable, counter-based edge delay and glitch filter for the stepdown control loop. It replaces fixed analog delay cells with a clocked, parametrised equivalent. Each edge type can be delayed by a runtime-programmable number of clock cycles, and pulses shorter than the delay are swallowed. The block sits between loop comparators and the control sequencer. The supply/ground/substrate pins stay on the symbol for schematic compatibility and have no logic function.

## Interface
Parameters:
- DLY_W, 8, width of delay count; max delay 2^DLY_W-1 cycles
- SYNC_STAGES, 2, input synchronizer depth (≥2)
- RST_VAL, 0, reset level of synchronizer and o
- DLY_RST, 10, reset value of delay register
- MODE_RST, 2'd0, reset value of mode register

Ports:
- CELCLK  in  1  clock
- CELRSTN  in  1  async active-low reset
- CELV, CELG, CELSUB  in  1  supply/ground/substrate, no logic function
- i  in  1  asynchronous input
- cfg_ld  in  1  strobe: capture dly_cfg, mode_cfg
- dly_cfg  in  DLY_W  delay in cycles
- mode_cfg  in  2  0=rise delayed, 1=fall delayed, 2=both delayed, 3=bypass
- o  out  1  delayed/filtered output, registered
- busy  out  1  high while a delayed transition is pending
- evt  out  1  one-cycle pulse on every o transition
- flt  out  1  one-cycle pulse when a pending transition is cancelled (glitch filtered)

## Operation
- i passes through SYNC_STAGES flops, giving si. All flops reset to RST_VAL, so no edge is generated out of reset.
- Config registers dly_q and mode_q load on cfg_ld. They are used from the cycle after the load.
- Edge classes:
  - A "delayed" edge is a rise (mode 0), a fall (mode 1), or either (mode 2).
  - Any other edge, and every edge in mode 3, is "direct".
- FSM has two states, IDLE and COUNT.
- IDLE, si == o: hold.
- IDLE, si != o, direct edge or dly_q == 0: o <= si next edge. Stay IDLE.
- IDLE, si != o, delayed edge with dly_q > 0: go to COUNT and load the counter so that o changes dly_q cycles after the direct-path timing.
- COUNT, si == target: decrement. At expiry, o <= si, evt, go to IDLE.
- COUNT, si reverts to o before expiry: cancel, flt pulses 1 cycle, go to IDLE. o is unchanged.
- COUNT, mode_q becomes 3: abort the count. o <= si next edge, no flt, go to IDLE.
- COUNT, dly_q changed by cfg_ld: the pending count is unaffected. The new value applies to the next detected edge.
- The counter never wraps. Its width is DLY_W. dly_q = 2^DLY_W-1 is legal.
- busy = (state == COUNT).
- Reset mid-count: immediate return to IDLE. Outputs take their reset values.

## Timing
- Reset values:
  - o = RST_VAL
  - busy = 0, evt = 0, flt = 0
  - dly_q = DLY_RST, mode_q = MODE_RST
  - counter = 0, state IDLE
- Let t be the first cycle si differs from o.
  - Direct edge: o toggles at edge t+1.
  - Delayed edge: o toggles at edge t+1+dly_q.
- From an i change sampled at edge k:
  - Direct: o changes at k+SYNC_STAGES.
  - Delayed: o changes at k+SYNC_STAGES+dly_q.
- A delayed transition passes only if si holds its new value for dly_q+1 consecutive cycles (t..t+dly_q). Shorter pulses are filtered, with flt pulsing the cycle after si reverts.
- evt is asserted in the same cycle o shows its new value.
- busy rises at t+1 and falls in the cycle o updates or the count is cancelled.
- cfg_ld coincident with edge detection at t: the edge uses the old config.
- Minimum accepted i pulse width: dly_q+1 cycles on delayed edges, 1 cycle on direct edges.

## Test plan
- Reset, SYNC_STAGES=2, defaults (dly_q=10, mode 0): i 0->1 sampled at edge 5 -> o rises at edge 17 with evt. busy is high from edge 7 through 16.
- Mode 0: i falls while o=1 -> o falls 2 cycles after sampling, evt pulses, busy stays 0.
- Mode 2, dly=10: i high pulse 8 cycles -> o stays 0, flt pulses once, no evt. Repeat with an 11-cycle pulse -> o is high for 11 cycles, delayed by 12.
- dly_cfg=0 via cfg_ld, mode 2 -> both edges show 2-cycle latency, busy never asserts. dly_cfg=255 -> rise appears after 257 cycles, with no counter wrap.
- Mid-count checks:
  - cfg_ld with dly_cfg=3 during a 10-cycle count -> the pending edge still takes 10 cycles; the next edge takes 3.
  - cfg_ld with mode_cfg=3 during a count -> o follows si next edge, no flt.
- CELRSTN asserted mid-count (async, between clock edges) -> o=RST_VAL and busy=0 immediately. After release with i stable at RST_VAL -> no evt.
